traffic_phase_timer: RTL and testbench

// Upstream sequencer for the traffic_lights FSM: times each light phase and issues the one-cycle
// 'change' pulse that advances it. Reads back the decoded lamp outputs (red/yellow/green) to track
// the current phase, shortens green on a pedestrian request, and flags a sticky fault if the lamps
// are illegal or the light FSM fails to advance after a pulse.

---
 rtl/traffic_phase_timer.sv | 169 ++++++++++++++++
 tb/tb_traffic_phase_timer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer
// Phase sequencer for the traffic_lights FSM. Times each lamp phase, issues a
// one-cycle 'change' pulse to advance the lights, follows the lamp feedback to
// learn the new phase, shortens green on a pedestrian request and raises a
// sticky fault on illegal lamps or a missing acknowledge.
module traffic_phase_timer #(
  parameter int CNT_W        = 16,
  parameter int RED_TICKS    = 50,
  parameter int GREEN_TICKS  = 40,
  parameter int YELLOW_TICKS = 10,
  parameter int MIN_GREEN    = 15,
  parameter int ACK_TIMEOUT  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             redin,
  input  logic             yellowin,
  input  logic             greenin,
  input  logic             ped_req,
  output logic             change,
  output logic             ped_wait,
  output logic             fault,
  output logic [CNT_W-1:0] count
);

  // Wait counter only needs to reach ACK_TIMEOUT-1.
  localparam int WT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PULSE,
    S_WAIT,
    S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    PH_RED,
    PH_YELLOW,
    PH_GREEN
  } phase_t;

  state_t          state;
  phase_t          phase;
  phase_t          lamp_phase;
  logic [WT_W-1:0] wait_cnt;
  logic [2:0]      lamps;
  logic            lamps_legal;
  logic            run_expire;
  logic            ped_set;
  logic            red_latch;

  // Last count value of a phase before it expires.
  function automatic logic [CNT_W-1:0] dur_last(input phase_t p);
    case (p)
      PH_GREEN:  dur_last = CNT_W'(GREEN_TICKS - 1);
      PH_YELLOW: dur_last = CNT_W'(YELLOW_TICKS - 1);
      default:   dur_last = CNT_W'(RED_TICKS - 1);
    endcase
  endfunction

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}})
      sat_inc = v;
    else
      sat_inc = v + CNT_W'(1);
  endfunction

  // Decode lamp feedback into legality and the phase it represents.
  always_comb begin
    lamps       = {redin, yellowin, greenin};
    lamps_legal = (lamps == 3'b100) || (lamps == 3'b010) || (lamps == 3'b001);
    lamp_phase  = PH_RED;
    if (greenin)
      lamp_phase = PH_GREEN;
    else if (yellowin)
      lamp_phase = PH_YELLOW;
  end

  // Expiry and pedestrian-latch qualifiers for the current cycle.
  always_comb begin
    run_expire = (count == dur_last(phase)) ||
                 ((phase == PH_GREEN) && ped_wait &&
                  (count >= CNT_W'(MIN_GREEN - 1)));
    ped_set    = ped_req && (phase != PH_RED);
    // A red phase gets latched either leaving IDLE or on an acknowledge in WAIT.
    red_latch  = lamps_legal && (lamp_phase == PH_RED) &&
                 (((state == S_IDLE) && enable) ||
                  ((state == S_WAIT) && (lamp_phase != phase)));
  end

  // Phase sequencer: state, latched phase, counters and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      phase    <= PH_RED;
      wait_cnt <= '0;
      change   <= 1'b0;
      ped_wait <= 1'b0;
      fault    <= 1'b0;
      count    <= '0;
    end else begin
      // Clearing on a red latch takes priority over a new request.
      if (red_latch)
        ped_wait <= 1'b0;
      else if (ped_set)
        ped_wait <= 1'b1;

      case (state)
        S_IDLE: begin
          if (enable && lamps_legal) begin
            phase <= lamp_phase;
            count <= '0;
            state <= S_RUN;
          end
        end

        S_RUN: begin
          if (!lamps_legal) begin
            fault <= 1'b1;
            state <= S_FAULT;
          end else if (enable) begin
            if (run_expire) begin
              change <= 1'b1;
              state  <= S_PULSE;
            end else begin
              count <= sat_inc(count);
            end
          end
        end

        S_PULSE: begin
          change   <= 1'b0;
          wait_cnt <= '0;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (!lamps_legal) begin
            fault <= 1'b1;
            state <= S_FAULT;
          end else if (lamp_phase != phase) begin
            // Any new legal phase is taken as the acknowledge.
            phase <= lamp_phase;
            count <= '0;
            state <= S_RUN;
          end else if (wait_cnt == WT_W'(ACK_TIMEOUT - 1)) begin
            fault <= 1'b1;
            state <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + WT_W'(1);
          end
        end

        S_FAULT: begin
          fault  <= 1'b1;
          change <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed testbench for traffic_phase_timer with a small lamp responder that
// advances red->green->yellow->red one edge after each change pulse.
module tb_traffic_phase_timer;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        redin;
  logic        yellowin;
  logic        greenin;
  logic        ped_req;
  logic        change;
  logic        ped_wait;
  logic        fault;
  logic [15:0] count;

  logic auto_ack;
  int   checks = 0;
  int   errors = 0;

  traffic_phase_timer #(
    .CNT_W       (16),
    .RED_TICKS   (4),
    .GREEN_TICKS (6),
    .YELLOW_TICKS(2),
    .MIN_GREEN   (3),
    .ACK_TIMEOUT (4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .redin   (redin),
    .yellowin(yellowin),
    .greenin (greenin),
    .ped_req (ped_req),
    .change  (change),
    .ped_wait(ped_wait),
    .fault   (fault),
    .count   (count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Lamp model: red -> green -> yellow -> red.
  task automatic advance_lamps();
    case ({redin, yellowin, greenin})
      3'b100:  begin redin = 1'b0; greenin  = 1'b1; end
      3'b001:  begin greenin = 1'b0; yellowin = 1'b1; end
      3'b010:  begin yellowin = 1'b0; redin  = 1'b1; end
      default: ;
    endcase
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    logic prev;
    prev = change;
    @(posedge clock);
    #1;
    if (auto_ack && prev)
      advance_lamps();
  endtask

  // From RUN with count=from-1, run out the phase, pulse, ack, and land in the
  // next phase's RUN with count=0.
  task automatic finish_phase(input int dur, input int from);
    for (int k = from; k < dur; k++) begin
      tick();
      chk("run_count", 32'(count), k);
      chk("run_nochg", 32'(change), 0);
    end
    tick();
    chk("pulse_hi", 32'(change), 1);
    tick();
    chk("pulse_lo", 32'(change), 0);
    tick();
    chk("next_cnt0", 32'(count), 0);
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    redin    = 1'b1;
    yellowin = 1'b0;
    greenin  = 1'b0;
    ped_req  = 1'b0;
    auto_ack = 1'b1;

    // Reset state
    tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_change", 32'(change), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_ped", 32'(ped_wait), 0);
    reset = 1'b0;

    // 1: full red -> green -> yellow -> red cycle
    tick();
    chk("idle_to_run", 32'(count), 0);
    finish_phase(4, 1);
    chk("green_lamp", 32'(greenin), 1);
    finish_phase(6, 1);
    chk("yellow_lamp", 32'(yellowin), 1);
    finish_phase(2, 1);
    chk("cycle_fault", 32'(fault), 0);

    // 2: ped request ignored in red, shortens green, cleared at red
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    chk("ped_red_ign", 32'(ped_wait), 0);
    chk("ped_red_cnt", 32'(count), 1);
    finish_phase(4, 2);
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    chk("ped_set", 32'(ped_wait), 1);
    chk("ped_g_cnt1", 32'(count), 1);
    tick();
    chk("ped_g_cnt2", 32'(count), 2);
    chk("ped_g_nochg", 32'(change), 0);
    tick();
    chk("ped_early_chg", 32'(change), 1);
    chk("ped_early_cnt", 32'(count), 2);
    tick();
    chk("ped_pulse_lo", 32'(change), 0);
    tick();
    chk("ped_yel_cnt0", 32'(count), 0);
    chk("ped_yel_hold", 32'(ped_wait), 1);
    finish_phase(2, 1);
    chk("ped_clr_red", 32'(ped_wait), 0);

    // 3: enable stall mid red
    tick();
    tick();
    chk("stall_pre", 32'(count), 2);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_cnt", 32'(count), 2);
      chk("stall_chg", 32'(change), 0);
    end
    enable = 1'b1;
    tick();
    chk("resume_cnt", 32'(count), 3);
    chk("resume_nochg", 32'(change), 0);
    tick();
    chk("resume_chg", 32'(change), 1);

    // 4: no acknowledge -> fault after ACK_TIMEOUT WAIT cycles
    auto_ack = 1'b0;
    tick();
    chk("wait_chg", 32'(change), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_nofault", 32'(fault), 0);
    end
    tick();
    chk("timeout_fault", 32'(fault), 1);
    chk("timeout_cnt", 32'(count), 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fault_sticky", 32'(fault), 1);
      chk("fault_nochg", 32'(change), 0);
    end
    reset = 1'b1;
    tick();
    chk("fault_rst", 32'(fault), 0);
    chk("fault_rst_cnt", 32'(count), 0);
    reset = 1'b0;

    // 5: illegal lamps in RUN, reset mid-PULSE
    auto_ack = 1'b1;
    tick();
    tick();
    chk("ill_pre_cnt", 32'(count), 1);
    greenin = 1'b1;
    tick();
    chk("ill_fault", 32'(fault), 1);
    greenin = 1'b0;
    reset = 1'b1;
    tick();
    chk("ill_rst", 32'(fault), 0);
    reset = 1'b0;
    tick();
    for (int k = 1; k < 4; k++) tick();
    chk("pre_pulse_cnt", 32'(count), 3);
    tick();
    chk("pulse_before_rst", 32'(change), 1);
    reset = 1'b1;
    tick();
    chk("rst_pulse_chg", 32'(change), 0);
    chk("rst_pulse_cnt", 32'(count), 0);
    reset = 1'b0;
    tick();
    chk("rst_reenter", 32'(count), 0);
    tick();
    chk("rst_reenter_run", 32'(count), 1);

    // Illegal lamps while IDLE: no fault, stays IDLE
    reset    = 1'b1;
    redin    = 1'b0;
    yellowin = 1'b0;
    greenin  = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("idle_ill_fault", 32'(fault), 0);
    chk("idle_ill_cnt", 32'(count), 0);
    yellowin = 1'b1;
    tick();
    chk("idle_exit_cnt", 32'(count), 0);
    tick();
    chk("idle_exit_cnt1", 32'(count), 1);
    tick();
    chk("idle_exit_chg", 32'(change), 1);
    chk("idle_exit_fault", 32'(fault), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
